tensor_core_operand_buffer: RTL and testbench

Double-buffered (ping-pong) operand store feeding the tensor core. It holds NUM_MATRICES square matrices per bank.
- The loader streams elements into the fill bank over a valid/ready handshake, with an auto-incrementing row-major address.
- The tensor core reads every element of the other (active) bank in parallel, in a single cycle.
- Banks swap on a handshake, so loading overlaps compute.

---
 rtl/tensor_core_pkg.sv | 29 ++
 rtl/tensor_core_operand_bank.sv | 42 ++++
 rtl/tensor_core_operand_buffer.sv | 101 ++++++++++
 tb/tb_tensor_core_operand_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tensor_core_pkg.sv
// Shared defaults, FSM state type and row-major element index decode for the
// tensor core operand buffer.
package tensor_core_pkg;

    localparam int TCOB_DATA_WIDTH   = 8;
    localparam int TCOB_MATRIX_DIM   = 4;
    localparam int TCOB_NUM_MATRICES = 2;

    typedef enum logic [0:0] {
        TCOB_FILL = 1'b0,
        TCOB_FULL = 1'b1
    } tcob_state_e;

    typedef struct packed {
        int matrix;
        int row;
        int col;
    } elem_idx_t;

    // Linear fill pointer -> {matrix, row, col} in row-major order.
    function automatic elem_idx_t elem_index(input int ptr, input int dim);
        elem_idx_t idx;
        idx.matrix = ptr / (dim * dim);
        idx.row    = (ptr / dim) % dim;
        idx.col    = ptr % dim;
        return idx;
    endfunction

endpackage

// File: rtl/tensor_core_operand_bank.sv
// One operand bank: single element write port, whole-bank clear, and every
// element presented in parallel on rd_data.
module tensor_core_operand_bank
    import tensor_core_pkg::*;
#(
    parameter int DATA_WIDTH   = TCOB_DATA_WIDTH,
    parameter int MATRIX_DIM   = TCOB_MATRIX_DIM,
    parameter int NUM_MATRICES = TCOB_NUM_MATRICES,
    parameter int PTR_W        = 5
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clear,
    output logic [NUM_MATRICES-1:0][MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] rd_data
);

    elem_idx_t wr_pos;

    always_comb wr_pos = elem_index(int'(wr_idx), MATRIX_DIM);

    // Clear wins over a write; the top never issues both in the same cycle.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            rd_data <= '0;
        end else begin
            for (int m = 0; m < NUM_MATRICES; m++) begin
                for (int r = 0; r < MATRIX_DIM; r++) begin
                    for (int c = 0; c < MATRIX_DIM; c++) begin
                        if (clear)
                            rd_data[m][r][c] <= '0;
                        else if (wr_en && wr_pos.matrix == m && wr_pos.row == r && wr_pos.col == c)
                            rd_data[m][r][c] <= wr_data;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tensor_core_operand_buffer.sv
// Ping-pong operand store for the tensor core: loader fills one bank while the
// core reads the other. Define TCOB_ZERO_ON_SWAP_EN to clear the new fill bank on swap.
module tensor_core_operand_buffer
    import tensor_core_pkg::*;
#(
    parameter int DATA_WIDTH   = TCOB_DATA_WIDTH,
    parameter int MATRIX_DIM   = TCOB_MATRIX_DIM,
    parameter int NUM_MATRICES = TCOB_NUM_MATRICES
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  write_valid_in,
    input  logic [DATA_WIDTH-1:0] write_data_in,
    output logic                  write_ready_out,
    input  logic                  load_abort_in,
    output logic                  fill_full_out,
    input  logic                  swap_req_in,
    output logic                  swap_ack_out,
    output logic                  active_valid_out,
    output logic                  active_bank_out,
    output logic [NUM_MATRICES-1:0][MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] read_data_out
);

    localparam int ELEMS = NUM_MATRICES * MATRIX_DIM * MATRIX_DIM;
    localparam int PTR_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ELEMS - 1);

    tcob_state_e      state;
    logic [PTR_W-1:0] ptr;
    logic             active_bank;
    logic             active_valid;
    logic             swap_ack;
    logic             write_xfer;
    logic             swap_fire;

    logic [NUM_MATRICES-1:0][MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] bank_rd [2];

    // Ready is forced low while reset is held, not just after the first edge.
    assign write_ready_out  = (state == TCOB_FILL) && reset_n_in;
    assign write_xfer       = write_valid_in && write_ready_out && !load_abort_in;
    assign swap_fire        = (state == TCOB_FULL) && swap_req_in && !load_abort_in;
    assign fill_full_out    = (state == TCOB_FULL);
    assign swap_ack_out     = swap_ack;
    assign active_valid_out = active_valid;
    assign active_bank_out  = active_bank;
    assign read_data_out    = active_bank ? bank_rd[1] : bank_rd[0];

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state        <= TCOB_FILL;
            ptr          <= '0;
            active_bank  <= 1'b0;
            active_valid <= 1'b0;
            swap_ack     <= 1'b0;
        end else begin
            swap_ack <= swap_fire;
            if (load_abort_in) begin
                ptr   <= '0;
                state <= TCOB_FILL;
            end else if (state == TCOB_FILL) begin
                if (write_xfer) begin
                    if (ptr == LAST_PTR) begin
                        ptr   <= '0;
                        state <= TCOB_FULL;
                    end else begin
                        ptr <= ptr + PTR_W'(1);
                    end
                end
            end else if (swap_req_in) begin
                active_bank  <= ~active_bank;
                active_valid <= 1'b1;
                state        <= TCOB_FILL;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic bank_clear;
`ifdef TCOB_ZERO_ON_SWAP_EN
        // The currently active bank becomes the fill bank on this swap.
        assign bank_clear = swap_fire && (active_bank == 1'(b));
`else
        assign bank_clear = 1'b0;
`endif
        tensor_core_operand_bank #(
            .DATA_WIDTH  (DATA_WIDTH),
            .MATRIX_DIM  (MATRIX_DIM),
            .NUM_MATRICES(NUM_MATRICES),
            .PTR_W       (PTR_W)
        ) u_bank (
            .clock_in  (clock_in),
            .reset_n_in(reset_n_in),
            .wr_en     (write_xfer && (active_bank != 1'(b))),
            .wr_idx    (ptr),
            .wr_data   (write_data_in),
            .clear     (bank_clear),
            .rd_data   (bank_rd[b])
        );
    end

endmodule

// File: tb/tb_tensor_core_operand_buffer.sv
// Randomized scoreboard bench for tensor_core_operand_buffer; the swap
// expectations are queued by the driver and retired by a negedge monitor.
module tb_tensor_core_operand_buffer;

    localparam int DW    = 8;
    localparam int D     = 4;
    localparam int NM    = 2;
    localparam int ELEMS = NM * D * D;
    localparam int VW    = ELEMS * DW;

    typedef logic [ELEMS-1:0][DW-1:0] set_t;
    typedef struct {
        int   cyc;
        logic bank;
        set_t data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          write_valid = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          write_ready;
    logic          load_abort = 1'b0;
    logic          fill_full;
    logic          swap_req = 1'b0;
    logic          swap_ack;
    logic          active_valid;
    logic          active_bank;
    logic [NM-1:0][D-1:0][D-1:0][DW-1:0] rd;

    tensor_core_operand_buffer dut (
        .clock_in        (clk),
        .reset_n_in      (rst_n),
        .write_valid_in  (write_valid),
        .write_data_in   (write_data),
        .write_ready_out (write_ready),
        .load_abort_in   (load_abort),
        .fill_full_out   (fill_full),
        .swap_req_in     (swap_req),
        .swap_ack_out    (swap_ack),
        .active_valid_out(active_valid),
        .active_bank_out (active_bank),
        .read_data_out   (rd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    // Reference model: bank contents, which bank is read, and fill progress.
    set_t mem [2];
    logic m_act, m_vld, m_full;
    int   m_cnt;
    exp_t sbq [$];
    exp_t e;

    task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                chk("swap_ack", VW'(swap_ack), VW'(1));
                chk("ack_bank", VW'(active_bank), VW'(e.bank));
                chk("ack_data", rd, e.data);
            end else begin
                chk("swap_ack_idle", VW'(swap_ack), VW'(0));
            end
        end
    end

    task automatic model_reset();
        mem[0] = '0;
        mem[1] = '0;
        m_act  = 1'b0;
        m_vld  = 1'b0;
        m_full = 1'b0;
        m_cnt  = 0;
        sbq.delete();
    endtask

    // Check outputs against the model, drive one cycle, advance the model.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic ab, input logic sw);
        chk("ready", VW'(write_ready), VW'(!m_full));
        chk("fill_full", VW'(fill_full), VW'(m_full));
        chk("active_valid", VW'(active_valid), VW'(m_vld));
        chk("active_bank", VW'(active_bank), VW'(m_act));
        chk("read_data", rd, mem[m_act]);
        write_valid = v;
        write_data  = d;
        load_abort  = ab;
        swap_req    = sw;
        if (ab) begin
            m_cnt  = 0;
            m_full = 1'b0;
        end else if (!m_full) begin
            if (v) begin
                mem[!m_act][m_cnt] = d;
                m_cnt++;
                if (m_cnt == ELEMS) begin
                    m_cnt  = 0;
                    m_full = 1'b1;
                end
            end
        end else if (sw) begin
`ifdef TCOB_ZERO_ON_SWAP_EN
            mem[m_act] = '0;
`endif
            m_act  = !m_act;
            m_vld  = 1'b1;
            m_full = 1'b0;
            sbq.push_back('{cyc + 1, m_act, mem[m_act]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, VW'(write_ready), VW'(0));
        chk({tag, "_full"}, VW'(fill_full), VW'(0));
        chk({tag, "_valid"}, VW'(active_valid), VW'(0));
        chk({tag, "_ack"}, VW'(swap_ack), VW'(0));
        chk({tag, "_bank"}, VW'(active_bank), VW'(0));
        chk({tag, "_data"}, rd, '0);
    endtask

    // Called at posedge+1: reset lands mid-cycle, before the next edge.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        write_valid = 1'b0;
        load_abort  = 1'b0;
        swap_req    = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] first_val;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: fill 1..32
        for (int i = 1; i <= ELEMS; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        chk("t1_full", VW'(fill_full), VW'(1));
        chk("t1_ready", VW'(write_ready), VW'(0));
        chk("t1_valid", VW'(active_valid), VW'(0));
        step(1'b1, 8'h55, 1'b0, 1'b0);

        // Test 2: swap
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t2_bank", VW'(active_bank), VW'(1));
        chk("t2_000", VW'(rd[0][0][0]), VW'(1));
        chk("t2_033", VW'(rd[0][3][3]), VW'(16));
        chk("t2_100", VW'(rd[1][0][0]), VW'(17));
        chk("t2_133", VW'(rd[1][3][3]), VW'(32));
        step(1'b0, '0, 1'b0, 1'b0);

        // Test 3: reload 100..131 while the active bank stays put
        for (int i = 0; i < ELEMS; i++) step(1'b1, DW'(100 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t3_bank", VW'(active_bank), VW'(0));
        chk("t3_000", VW'(rd[0][0][0]), VW'(100));
        step(1'b0, '0, 1'b0, 1'b0);

        // Test 4: abort with a same-cycle write
        for (int i = 0; i < 10; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        first_val = DW'($urandom);
        step(1'b1, first_val, 1'b0, 1'b0);
        for (int i = 1; i < ELEMS - 1; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        chk("t4_not_full", VW'(fill_full), VW'(0));
        step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t4_first", VW'(rd[0][0][0]), VW'(first_val));
        step(1'b0, '0, 1'b0, 1'b0);

        // Test 5: swap request held through the whole fill
        for (int i = 0; i < ELEMS; i++) step(1'b1, DW'($urandom), 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        // Test 6: asynchronous reset mid-fill
        for (int i = 0; i < 7; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        async_reset();
        chk("t6_data_zero", rd, '0);

        // Partial reload after swaps exercises the zero-on-swap build too
        for (int i = 0; i < ELEMS; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < ELEMS; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, DW'($urandom),
                 $urandom_range(0, 60) == 0, $urandom_range(0, 3) == 0);
            if (i == 1500) async_reset();
        end
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        chk("sb_drain", VW'(sbq.size()), VW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
